// File: rtl/risc_run_ctrl_pkg.sv
// risc_ctrl_pkg: shared encodings for the miniRISC run/step/halt sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state encoding, stop-cause codes, default PC/counter widths.
package risc_ctrl_pkg;

  localparam int PC_W_DEF  = 10;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_STEP      = 2'd0,
    CAUSE_HALT_INSN = 2'd1,
    CAUSE_USER      = 2'd2,
    CAUSE_BP        = 2'd3
  } cause_e;

endpackage

// File: rtl/risc_run_ctrl_if.sv
// risc_run_ctrl_if: board-command / core-status bundle for the run controller.
// Latency: n/a (wiring only).
// Backpressure: none; commands are single-cycle pulses, status is level.
// master = board/wrapper side (drives commands, pc, halt_insn); slave = controller.
interface risc_run_ctrl_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             run;
  logic             step;
  logic             stop;
  logic             clr;
  logic             bp_set;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  pc;
  logic             halt_insn;
  logic             core_en;
  logic [1:0]       state_o;
  logic [1:0]       cause_o;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output run, step, stop, clr, bp_set, bp_addr, pc, halt_insn,
    input  core_en, state_o, cause_o, cycle_cnt
  );

  modport slave (
    input  run, step, stop, clr, bp_set, bp_addr, pc, halt_insn,
    output core_en, state_o, cause_o, cycle_cnt
  );
endinterface

// File: rtl/risc_run_ctrl_sat_counter.sv
// risc_sat_counter: CNT_W-bit up-counter that sticks at all-ones, sync clear.
// Latency: count visible one cycle after inc_i.
// Backpressure: none.
// Ports: clk, rst (async active-low), inc_i, clr_i (wins over inc_i), cnt_o.
module risc_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (inc_i && ~&cnt_q)     cnt_d = cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/risc_run_ctrl.sv
// risc_run_ctrl: run/step/halt sequencer gating the miniRISC clock-enable.
// Latency: state changes on the command edge; core_en is combinational (0-cycle breakpoint).
// Backpressure: none; commands are pulses, ignored when not legal in the current state.
// Ports: clk, rst (async active-low), bus (risc_run_ctrl_if.slave).
// Breakpoint logic is present only when RISC_CTRL_BREAKPOINT_EN is defined.
module risc_run_ctrl
  import risc_ctrl_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  risc_run_ctrl_if.slave  bus
);
  state_e state_q, state_d;
  cause_e cause_q, cause_d;
  logic   bp_hit;
  logic   core_en;

`ifdef RISC_CTRL_BREAKPOINT_EN
  logic            armed_q;
  logic [PC_W-1:0] bp_q;
  logic            skip_q, skip_d;

  // skip masks the breakpoint for the single RUN cycle that resumes from HALT,
  // so resuming at the breakpoint address does not re-trigger immediately.
  assign skip_d = !bus.clr && (state_q == ST_HALT) &&
                  (cause_q != CAUSE_HALT_INSN) && bus.run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q <= 1'b0;
      bp_q    <= '0;
      skip_q  <= 1'b0;
    end else begin
      if (bus.bp_set) begin
        armed_q <= 1'b1;
        bp_q    <= bus.bp_addr;
      end
      skip_q <= skip_d;
    end
  end

  assign bp_hit = armed_q && (bus.pc == bp_q) && !skip_q;
`else
  logic unused_bp;
  assign unused_bp = bus.bp_set ^ (^bus.bp_addr) ^ (^bus.pc);
  assign bp_hit    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cause_q <= CAUSE_STEP;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    if (bus.clr) begin
      state_d = ST_IDLE;
      cause_d = CAUSE_STEP;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.run)       state_d = ST_RUN;
          else if (bus.step) state_d = ST_STEP;
        end
        ST_RUN: begin
          if (bus.halt_insn) begin
            state_d = ST_HALT;
            cause_d = CAUSE_HALT_INSN;
          end else if (bp_hit) begin
            state_d = ST_HALT;
            cause_d = CAUSE_BP;
          end else if (bus.stop) begin
            state_d = ST_HALT;
            cause_d = CAUSE_USER;
          end
        end
        ST_STEP: begin
          state_d = ST_HALT;
          cause_d = bus.halt_insn ? CAUSE_HALT_INSN : CAUSE_STEP;
        end
        ST_HALT: begin
          // A HALT instruction parks the core until clr.
          if (cause_q != CAUSE_HALT_INSN) begin
            if (bus.run)       state_d = ST_RUN;
            else if (bus.step) state_d = ST_STEP;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic: a breakpoint hit suppresses the enable in the same cycle.
  always_comb begin
    core_en = 1'b0;
    if (state_q == ST_STEP)                 core_en = 1'b1;
    else if (state_q == ST_RUN && !bp_hit)  core_en = 1'b1;
  end

  risc_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (core_en),
    .clr_i (bus.clr),
    .cnt_o (bus.cycle_cnt)
  );

  assign bus.core_en = core_en;
  assign bus.state_o = state_q;
  assign bus.cause_o = cause_q;
endmodule

// File: tb/tb_risc_run_ctrl.sv
// tb_risc_run_ctrl: directed scenarios plus random pulses, checked every cycle
// against a behavioural model of the run/step/halt rules.
module tb_risc_run_ctrl;
  localparam int PC_W  = 10;
  localparam int CNT_W = 16;
`ifdef RISC_CTRL_BREAKPOINT_EN
  localparam bit BPEN = 1'b1;
`else
  localparam bit BPEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  risc_run_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  risc_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: mode 0 idle, 1 running, 2 single step, 3 halted.
  int m_mode, m_cause, m_cnt, m_bp;
  bit m_armed, m_skip;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_cause = 0; m_cnt = 0; m_bp = 0; m_armed = 0; m_skip = 0;
  endtask

  function automatic bit m_hit();
    return BPEN && m_armed && !m_skip && (int'(bus.pc) == m_bp);
  endfunction

  function automatic bit m_en();
    return (m_mode == 2) || (m_mode == 1 && !m_hit());
  endfunction

  task automatic m_advance();
    int nm = m_mode;
    int nc = m_cause;
    bit en = m_en();
    bit hit = m_hit();
    bit resumed = 0;
    if (bus.clr) begin
      nm = 0; nc = 0;
    end else if (m_mode == 0) begin
      if (bus.run) nm = 1; else if (bus.step) nm = 2;
    end else if (m_mode == 1) begin
      if (bus.halt_insn)  begin nm = 3; nc = 1; end
      else if (hit)       begin nm = 3; nc = 3; end
      else if (bus.stop)  begin nm = 3; nc = 2; end
    end else if (m_mode == 2) begin
      nm = 3; nc = bus.halt_insn ? 1 : 0;
    end else if (m_cause != 1) begin
      if (bus.run) begin nm = 1; resumed = 1; end
      else if (bus.step) nm = 2;
    end
    m_skip = BPEN && resumed;
    if (bus.clr) m_cnt = 0;
    else if (en && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    if (BPEN && bus.bp_set) begin m_bp = int'(bus.bp_addr); m_armed = 1; end
    m_mode = nm; m_cause = nc;
  endtask

  // Called at posedge+1: checks mid-cycle, advances the model, crosses the edge.
  task automatic tick();
    #4;
    chk("core_en", 32'(bus.core_en), 32'(m_en()));
    chk("state", 32'(bus.state_o), 32'(m_mode));
    chk("cause", 32'(bus.cause_o), 32'(m_cause));
    chk("cycle_cnt", 32'(bus.cycle_cnt), 32'(m_cnt));
    m_advance();
    @(posedge clk); #1;
    bus.run = 0; bus.step = 0; bus.stop = 0; bus.clr = 0;
    bus.bp_set = 0; bus.halt_insn = 0;
  endtask

  // Simple core: pc advances on enabled cycles, optional backward branch.
  task automatic run_core(input int start_pc, input int wrap_at, input int wrap_to,
                          input int halt_pc, input int max_cyc, output int end_pc);
    int cpc = start_pc;
    for (int i = 0; i < max_cyc && m_mode == 1; i++) begin
      bit en;
      bus.pc = PC_W'(cpc);
      bus.halt_insn = (cpc == halt_pc);
      en = m_en();
      tick();
      if (en) cpc = (cpc == wrap_at) ? wrap_to : cpc + 1;
    end
    end_pc = cpc;
    chk("run_reaches_halt", 32'(bus.state_o), 32'd3);
  endtask

  int end_pc;

  initial begin
    bus.run = 0; bus.step = 0; bus.stop = 0; bus.clr = 0;
    bus.bp_set = 0; bus.bp_addr = '0; bus.pc = '0; bus.halt_insn = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_core_en", 32'(bus.core_en), 32'd0);
    chk("rst_state", 32'(bus.state_o), 32'd0);
    chk("rst_cause", 32'(bus.cause_o), 32'd0);
    chk("rst_cnt", 32'(bus.cycle_cnt), 32'd0);
    rst = 1;
    @(posedge clk); #1;

    // HALT instruction on the fifth running cycle; later run ignored; clr.
    bus.run = 1; tick();
    run_core(0, -1, -1, 4, 20, end_pc);
    chk("halt_cause", 32'(bus.cause_o), 32'd1);
    chk("halt_cnt", 32'(bus.cycle_cnt), 32'd5);
    bus.run = 1; tick();
    chk("halt_run_ignored", 32'(bus.state_o), 32'd3);
    bus.clr = 1; tick();
    chk("clr_state", 32'(bus.state_o), 32'd0);
    chk("clr_cnt", 32'(bus.cycle_cnt), 32'd0);

    // Breakpoint at 0x00A.
    bus.bp_set = 1; bus.bp_addr = 10'h00A; tick();
    bus.pc = '0; bus.run = 1; tick();
    run_core(0, -1, -1, 20, 40, end_pc);
`ifdef RISC_CTRL_BREAKPOINT_EN
    chk("bp_cause", 32'(bus.cause_o), 32'd3);
    chk("bp_cnt", 32'(bus.cycle_cnt), 32'd10);
    chk("bp_pc", 32'(end_pc), 32'd10);
    // Resume at the breakpoint (skipped once), loop 12->8, hit again.
    bus.pc = 10'h00A; bus.run = 1; tick();
    run_core(10, 12, 8, 99, 40, end_pc);
    chk("bp2_cause", 32'(bus.cause_o), 32'd3);
    chk("bp2_cnt", 32'(bus.cycle_cnt), 32'd15);
    chk("bp2_pc", 32'(end_pc), 32'd10);
`else
    chk("nobp_cause", 32'(bus.cause_o), 32'd1);
    chk("nobp_cnt", 32'(bus.cycle_cnt), 32'd21);
`endif
    bus.clr = 1; tick();

    // Three single steps, then stop in HALT is ignored.
    for (int k = 0; k < 3; k++) begin
      bus.step = 1; tick();
      tick();
    end
    chk("step_cnt", 32'(bus.cycle_cnt), 32'd3);
    chk("step_cause", 32'(bus.cause_o), 32'd0);
    bus.stop = 1; tick();
    chk("stop_in_halt", 32'(bus.state_o), 32'd3);
    chk("stop_in_halt_cause", 32'(bus.cause_o), 32'd0);

    // run+step together; stop+halt_insn together; async reset mid-run.
    bus.clr = 1; tick();
    bus.pc = '0; bus.run = 1; bus.step = 1; tick();
    chk("run_beats_step", 32'(bus.state_o), 32'd1);
    tick(); tick();
    bus.stop = 1; bus.halt_insn = 1; tick();
    chk("halt_beats_stop", 32'(bus.cause_o), 32'd1);
    bus.clr = 1; tick();
    bus.run = 1; tick();
    tick();
    chk("pre_rst_en", 32'(bus.core_en), 32'd1);
    rst = 0; #1;
    chk("async_rst_en", 32'(bus.core_en), 32'd0);
    chk("async_rst_state", 32'(bus.state_o), 32'd0);
    m_reset();
    @(posedge clk); #1;
    rst = 1;
    tick();

    // Random pulses against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.run       = ($urandom_range(0, 99) < 8);
      bus.step      = ($urandom_range(0, 99) < 6);
      bus.stop      = ($urandom_range(0, 99) < 5);
      bus.clr       = ($urandom_range(0, 99) < 3);
      bus.bp_set    = ($urandom_range(0, 99) < 3);
      bus.halt_insn = ($urandom_range(0, 99) < 4);
      bus.bp_addr   = PC_W'($urandom_range(0, 15));
      bus.pc        = PC_W'($urandom_range(0, 15));
      tick();
    end

    // Saturation: run up to 0xFFFE, then four more enabled cycles.
    bus.clr = 1; tick();
    bus.bp_set = 1; bus.bp_addr = 10'h3FF; tick();
    bus.pc = '0; bus.run = 1; tick();
    repeat (65533) tick();
    bus.stop = 1; tick();
    chk("sat_pre", 32'(bus.cycle_cnt), 32'hFFFE);
    bus.run = 1; tick();
    repeat (4) tick();
    chk("sat_hold", 32'(bus.cycle_cnt), 32'hFFFF);
    bus.stop = 1; tick();
    chk("sat_final", 32'(bus.cycle_cnt), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
